// File: rtl/clk_div_meter_pkg.sv
// Shared types and default constants for the divided-clock meter.
package clk_meter_pkg;

   typedef enum logic {
      WAIT_EDGE = 1'b0,
      COUNT     = 1'b1
   } state_t;

   localparam int          DEF_CNT_W       = 32;
   localparam int          DEF_SYNC_STAGES = 2;
   localparam int          DEF_LOCK_COUNT  = 4;
   localparam logic [31:0] DEF_TIMEOUT     = 32'h00FF_FFFF;

endpackage

// File: rtl/clk_div_meter_if.sv
// Measurement bus of clk_div_meter: the slow input and the reported result.
interface clk_div_meter_if #(
   parameter int CNT_W = 32
);
   logic             sig_in;
   logic [CNT_W-1:0] div_meas;
   logic             meas_valid;
   logic             locked;
   logic             timeout;

   modport master (
      output sig_in,
      input  div_meas, meas_valid, locked, timeout
   );

   modport slave (
      input  sig_in,
      output div_meas, meas_valid, locked, timeout
   );
endinterface

// File: rtl/clk_div_meter_sync_edge_det.sv
// Multi-stage synchronizer followed by a registered XOR detector that flags
// both rising and falling transitions of an asynchronous input.
module sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic async_in,
   output logic edge_pulse
);
   logic [STAGES-1:0] sync_r;
   logic              sync_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '0;
         sync_q <= 1'b0;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], async_in};
         sync_q <= sync_r[STAGES-1];
      end
   end

   assign edge_pulse = sync_r[STAGES-1] ^ sync_q;
endmodule

// File: rtl/clk_div_meter.sv
// Measures the edge spacing of a divided clock and reports the divider value,
// with lock and timeout status. CLK_DIV_METER_TOL_EN accepts +/-1 matches.
//
//   state     | meaning
//   WAIT_EDGE | idle after reset or timeout; next edge arms counting
//   COUNT     | counting clk_in cycles between successive edges
module clk_div_meter
   import clk_meter_pkg::*;
#(
   parameter int               CNT_W       = DEF_CNT_W,
   parameter int               SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int               LOCK_COUNT  = DEF_LOCK_COUNT,
   parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(DEF_TIMEOUT)
) (
   input  logic            clk_in,
   input  logic            rst_n,
   clk_div_meter_if.slave  bus
);
   localparam int                 MATCH_W   = $clog2(LOCK_COUNT);
   localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [CNT_W-1:0]   TO_LAST   = TIMEOUT - CNT_W'(1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   prev_q, prev_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               valid_q, valid_d;
   logic               locked_q, locked_d;
   logic               timeout_q, timeout_d;
   logic               first_q, first_d;
   logic               edge_pulse;
   logic               is_match;

   sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_edge_det (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .async_in   (bus.sig_in),
      .edge_pulse (edge_pulse)
   );

`ifdef CLK_DIV_METER_TOL_EN
   logic [CNT_W-1:0] diff;

   always_comb begin
      diff     = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
      is_match = (diff <= CNT_W'(1));
   end
`else
   assign is_match = (cnt_q == prev_q);
`endif

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= WAIT_EDGE;
         cnt_q     <= '0;
         div_q     <= '0;
         prev_q    <= '0;
         match_q   <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
         first_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         prev_q    <= prev_d;
         match_q   <= match_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
         first_q   <= first_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      prev_d    = prev_q;
      match_d   = match_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      first_d   = first_q;

      case (state_q)
         WAIT_EDGE: begin
            cnt_d = '0;
            if (edge_pulse) begin
               timeout_d = 1'b0;
               first_d   = 1'b1;
               state_d   = COUNT;
            end
         end
         COUNT: begin
            // An edge takes priority over the timeout terminal count.
            if (edge_pulse) begin
               div_d   = cnt_q;
               valid_d = 1'b1;
               cnt_d   = '0;
               prev_d  = cnt_q;
               first_d = 1'b0;
               if (first_q) begin
                  match_d = '0;
               end else if (is_match) begin
                  if (match_q != MATCH_MAX) begin
                     match_d = match_q + MATCH_W'(1);
                  end
                  if (match_q >= MATCH_MAX - MATCH_W'(1)) begin
                     locked_d = 1'b1;
                  end
               end else begin
                  match_d  = '0;
                  locked_d = 1'b0;
               end
            end else if (cnt_q == TO_LAST) begin
               timeout_d = 1'b1;
               locked_d  = 1'b0;
               match_d   = '0;
               cnt_d     = '0;
               state_d   = WAIT_EDGE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = WAIT_EDGE;
      endcase
   end

   assign bus.div_meas   = div_q;
   assign bus.meas_valid = valid_q;
   assign bus.locked     = locked_q;
   assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_clk_div_meter.sv
// Directed bench for clk_div_meter: divider patterns, rate change, timeout,
// fast toggling, mid-run reset and +/-1 tolerance (CLK_DIV_METER_TOL_EN aware).
module tb_clk_div_meter;
   localparam int CNT_W = 32;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;

   clk_div_meter_if #(.CNT_W(CNT_W)) bus ();

   clk_div_meter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (2),
      .LOCK_COUNT  (4),
      .TIMEOUT     (32'd1000)
   ) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n_meas = 0;
   int          last_meas_cyc = 0;
   int          last_gap = 0;
   logic [31:0] div_hist [0:255];
   logic        lock_hist [0:255];

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (bus.meas_valid === 1'b1) begin
         div_hist[n_meas % 256]  = bus.div_meas;
         lock_hist[n_meas % 256] = bus.locked;
         last_gap      = cyc - last_meas_cyc;
         last_meas_cyc = cyc;
         n_meas++;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic run(input int cnt, input int period);
      repeat (cnt) begin
         bus.sig_in = ~bus.sig_in;
         wait_cyc(period);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      bus.sig_in = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(2);
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      bus.sig_in = 1'b0;
      #2;
      checks++;
      if (bus.div_meas !== 32'd0) begin errors++; $display("FAIL reset_div got %0d exp 0", bus.div_meas); end
      checks++;
      if (bus.meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.meas_valid); end
      checks++;
      if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", bus.locked); end
      checks++;
      if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", bus.timeout); end
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(2);
   endtask

   task automatic test_div3();
      int base;
      do_reset();
      base = n_meas;
      run(9, 4);
      wait_cyc(8);
      checks++;
      if (n_meas - base !== 8) begin errors++; $display("FAIL div3_count got %0d exp 8", n_meas - base); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (div_hist[(base + i) % 256] !== 32'd3) begin
            errors++; $display("FAIL div3_value[%0d] got %0d exp 3", i, div_hist[(base + i) % 256]);
         end
      end
      checks++;
      if (lock_hist[(base + 2) % 256] !== 1'b0) begin errors++; $display("FAIL div3_lock3 got %b exp 0", lock_hist[(base + 2) % 256]); end
      checks++;
      if (lock_hist[(base + 3) % 256] !== 1'b1) begin errors++; $display("FAIL div3_lock4 got %b exp 1", lock_hist[(base + 3) % 256]); end
      checks++;
      if (last_gap !== 4) begin errors++; $display("FAIL div3_gap got %0d exp 4", last_gap); end
   endtask

   task automatic test_div_change();
      int base;
      do_reset();
      base = n_meas;
      run(6, 101);
      checks++;
      if (n_meas - base !== 5) begin errors++; $display("FAIL chg_count100 got %0d exp 5", n_meas - base); end
      checks++;
      if (bus.div_meas !== 32'd100) begin errors++; $display("FAIL chg_div100 got %0d exp 100", bus.div_meas); end
      checks++;
      if (bus.locked !== 1'b1) begin errors++; $display("FAIL chg_lock100 got %b exp 1", bus.locked); end
      run(5, 51);
      checks++;
      if (n_meas - base !== 10) begin errors++; $display("FAIL chg_count50 got %0d exp 10", n_meas - base); end
      checks++;
      if (lock_hist[(base + 5) % 256] !== 1'b1) begin errors++; $display("FAIL chg_lock_last100 got %b exp 1", lock_hist[(base + 5) % 256]); end
      checks++;
      if (div_hist[(base + 6) % 256] !== 32'd50) begin errors++; $display("FAIL chg_first50 got %0d exp 50", div_hist[(base + 6) % 256]); end
      checks++;
      if (lock_hist[(base + 6) % 256] !== 1'b0) begin errors++; $display("FAIL chg_unlock got %b exp 0", lock_hist[(base + 6) % 256]); end
      checks++;
      if (lock_hist[(base + 8) % 256] !== 1'b0) begin errors++; $display("FAIL chg_lock3of50 got %b exp 0", lock_hist[(base + 8) % 256]); end
      checks++;
      if (lock_hist[(base + 9) % 256] !== 1'b1) begin errors++; $display("FAIL chg_relock got %b exp 1", lock_hist[(base + 9) % 256]); end
   endtask

   task automatic test_timeout();
      int base;
      int to_cyc;
      do_reset();
      base = n_meas;
      run(5, 20);
      checks++;
      if (bus.locked !== 1'b1) begin errors++; $display("FAIL to_prelock got %b exp 1", bus.locked); end
      to_cyc = -1;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk_in);
         if (bus.timeout === 1'b1) begin
            to_cyc = cyc;
            break;
         end
      end
      checks++;
      if (to_cyc - last_meas_cyc !== 1000) begin
         errors++; $display("FAIL to_delay got %0d exp 1000 (seen=%0d)", to_cyc - last_meas_cyc, to_cyc != -1);
      end
      checks++;
      if (bus.locked !== 1'b0) begin errors++; $display("FAIL to_locked got %b exp 0", bus.locked); end
      checks++;
      if (bus.div_meas !== 32'd19) begin errors++; $display("FAIL to_div_kept got %0d exp 19", bus.div_meas); end
      @(posedge clk_in);
      #1;
      base = n_meas;
      bus.sig_in = ~bus.sig_in;
      wait_cyc(10);
      checks++;
      if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", bus.timeout); end
      checks++;
      if (n_meas - base !== 0) begin errors++; $display("FAIL to_arm_nomeas got %0d exp 0", n_meas - base); end
      wait_cyc(990);
      bus.sig_in = ~bus.sig_in;
      wait_cyc(10);
      checks++;
      if (n_meas - base !== 1) begin errors++; $display("FAIL to_edge_count got %0d exp 1", n_meas - base); end
      checks++;
      if (bus.div_meas !== 32'd999) begin errors++; $display("FAIL to_edge_wins got %0d exp 999", bus.div_meas); end
      checks++;
      if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_edge_notimeout got %b exp 0", bus.timeout); end
   endtask

   task automatic test_fast();
      int base;
      do_reset();
      base = n_meas;
      run(10, 1);
      wait_cyc(8);
      checks++;
      if (n_meas - base !== 9) begin errors++; $display("FAIL fast_count got %0d exp 9", n_meas - base); end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (div_hist[(base + i) % 256] !== 32'd0) begin
            errors++; $display("FAIL fast_value[%0d] got %0d exp 0", i, div_hist[(base + i) % 256]);
         end
      end
      checks++;
      if (bus.locked !== 1'b1) begin errors++; $display("FAIL fast_locked got %b exp 1", bus.locked); end
   endtask

   task automatic test_reset_mid();
      int base;
      do_reset();
      run(6, 21);
      checks++;
      if (bus.locked !== 1'b1) begin errors++; $display("FAIL rmid_prelock got %b exp 1", bus.locked); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.div_meas !== 32'd0) begin errors++; $display("FAIL rmid_div got %0d exp 0", bus.div_meas); end
      checks++;
      if (bus.locked !== 1'b0) begin errors++; $display("FAIL rmid_locked got %b exp 0", bus.locked); end
      checks++;
      if (bus.meas_valid !== 1'b0 || bus.timeout !== 1'b0) begin
         errors++; $display("FAIL rmid_flags got valid=%b timeout=%b exp 0 0", bus.meas_valid, bus.timeout);
      end
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(2);
      base = n_meas;
      run(1, 21);
      checks++;
      if (n_meas - base !== 0) begin errors++; $display("FAIL rmid_arm got %0d exp 0", n_meas - base); end
      run(1, 21);
      checks++;
      if (n_meas - base !== 1) begin errors++; $display("FAIL rmid_count got %0d exp 1", n_meas - base); end
      checks++;
      if (bus.div_meas !== 32'd20) begin errors++; $display("FAIL rmid_div20 got %0d exp 20", bus.div_meas); end
   endtask

   task automatic test_tolerance();
      int   base;
      logic exp_lock;
`ifdef CLK_DIV_METER_TOL_EN
      exp_lock = 1'b1;
`else
      exp_lock = 1'b0;
`endif
      do_reset();
      base = n_meas;
      repeat (4) begin
         run(1, 10);
         run(1, 11);
      end
      run(1, 10);
      wait_cyc(8);
      checks++;
      if (n_meas - base !== 8) begin errors++; $display("FAIL tol_count got %0d exp 8", n_meas - base); end
      checks++;
      if (div_hist[base % 256] !== 32'd9) begin errors++; $display("FAIL tol_raw9 got %0d exp 9", div_hist[base % 256]); end
      checks++;
      if (div_hist[(base + 1) % 256] !== 32'd10) begin errors++; $display("FAIL tol_raw10 got %0d exp 10", div_hist[(base + 1) % 256]); end
      checks++;
      if (lock_hist[(base + 3) % 256] !== exp_lock) begin
         errors++; $display("FAIL tol_lock4 got %b exp %b", lock_hist[(base + 3) % 256], exp_lock);
      end
      checks++;
      if (bus.locked !== exp_lock) begin errors++; $display("FAIL tol_locked got %b exp %b", bus.locked, exp_lock); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.sig_in = 1'b0;
      test_reset();
      test_div3();
      test_div_change();
      test_timeout();
      test_fast();
      test_reset_mid();
      test_tolerance();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/clk_div_meter.md
Name: clk_div_meter

Overview:
- Receive-side counterpart of the team's clock divider. It measures a divided square wave (sig_in) in clk_in cycles and reports the equivalent divider setting (clk_div value).
- Sits beside the audio/speech timing path. Used to confirm that a generated sample clock runs at the programmed rate, and to recover the divider value of an external slow clock.
- Reports each measurement with a valid pulse, a lock indication, and a timeout flag.

Parameters:
- CNT_W, 32, width of the interval counter and of div_meas.
- SYNC_STAGES, 2, flip-flop stages in the sig_in synchronizer (minimum 2).
- LOCK_COUNT, 4, number of consecutive identical measurements required to assert locked (minimum 2).
- TIMEOUT, 32'h00FF_FFFF, cycles without a sig_in edge before timeout is declared (must be < 2^CNT_W).

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sig_in  input  1  divided clock to measure; asynchronous to clk_in, no timing relation assumed.
- div_meas  output  CNT_W  last measured divider value = clk_in cycles between sig_in edges minus 1.
- meas_valid  output  1  one-cycle pulse when div_meas updates.
- locked  output  1  high after LOCK_COUNT consecutive identical measurements.
- timeout  output  1  high when no edge has been seen for TIMEOUT cycles.

Behaviour:
- Reset (async assert, sync deassert by construction):
  - Outputs: div_meas=0, meas_valid=0, locked=0, timeout=0.
  - Internal: synchronizer=0, edge register=0, cnt=0, match_cnt=0, prev_meas=0, state=WAIT_EDGE.
- Edge detect:
  - sig_in passes through SYNC_STAGES flops, then one more register.
  - edge = sync_out XOR sync_q. Both rising and falling edges count, because the divider toggles once per clk_div+1 cycles.
- State WAIT_EDGE:
  - cnt holds 0; no measurement is produced.
  - On edge: cnt<=0, clear timeout, go to COUNT.
- State COUNT, each cycle:
  - No edge and cnt != TIMEOUT-1: cnt<=cnt+1.
  - Edge:
    - div_meas<=cnt, meas_valid<=1 next cycle, cnt<=0, stay in COUNT.
    - Lock update per the lock rule below.
    - prev_meas<=cnt.
  - No edge and cnt == TIMEOUT-1: timeout<=1 (sticky until the next edge), locked<=0, match_cnt<=0, cnt<=0, go to WAIT_EDGE.
    - div_meas keeps its last value.
- Lock rule (exact build):
  - First measurement after WAIT_EDGE: match_cnt<=0.
  - Subsequent measurement equal to prev_meas: match_cnt<=match_cnt+1, saturating at LOCK_COUNT-1.
  - Otherwise: match_cnt<=0, locked<=0.
  - locked<=1 on the measurement that brings match_cnt to LOCK_COUNT-1.
- Latency:
  - sig_in transition to edge: SYNC_STAGES+1 cycles.
  - edge to meas_valid/div_meas: 1 cycle.
  - Synchronizer delay is constant, so measured intervals are exact for stable input. ±1 jitter is possible from metastability resolution.
- Arithmetic: cnt never wraps, because timeout fires first.
- Boundary cases:
  - Edges on consecutive cycles give div_meas=0.
  - Edge on the same cycle cnt reaches TIMEOUT-1: the edge wins, the measurement is taken, and no timeout is declared.
- Reset mid-measurement: all state clears immediately; the first post-reset edge only arms measurement.

Optional Feature:
- Macro: CLK_DIV_METER_TOL_EN.
- Defined: a measurement "matches" when |cnt - prev_meas| <= 1, absorbing synchronizer jitter. On each match, prev_meas updates to the new value.
- Undefined: only exact equality matches.
- div_meas always reports the raw count in both builds.

Decomposition:
- Shared package clk_meter_pkg:
  - state enum (WAIT_EDGE, COUNT);
  - default constants for CNT_W, SYNC_STAGES, LOCK_COUNT, TIMEOUT.
- One natural sub-module: sync_edge_det. Parameterised synchronizer plus registered XOR edge detector, reusable for other async inputs.
- Counter, FSM and lock logic stay in clk_div_meter.

Test Plan:
- Drive sig_in from the team's divider with clk_div=3 (toggle every 4 cycles) -> meas_valid pulses every 4 cycles, div_meas=3, locked=1 on the 4th measurement.
- clk_div=100, then switch to 50 mid-run -> div_meas=100, locked=1; the first 50 value clears locked; re-lock after 4 measurements of 50.
- TIMEOUT=1000, stop sig_in toggling -> timeout=1 and locked=0 exactly 1000 cycles after the last edge; the next edge clears timeout without meas_valid; the following edge produces a measurement.
- Toggle sig_in every clk_in cycle -> div_meas=0 on each meas_valid.
- Assert rst_n=0 mid-count with clk_div=20 -> all outputs 0 immediately; after release, the first measurement appears on the 2nd edge, with div_meas=20.
- With CLK_DIV_METER_TOL_EN defined, alternate intervals 10/11 (div_meas 9/10) -> locked=1. Without the macro, same stimulus -> locked stays 0.
